// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for wb_rr_arbiter: flattened Wishbone master-side slices, the single
// slave-side port and the one-hot grant. The arbiter uses the slave modport.
interface wb_rr_arbiter_if #(
   parameter int NUM_MASTERS = 4,
   parameter int DATA_WIDTH  = 128,
   parameter int ADDR_WIDTH  = 32,
   parameter int SEL_WIDTH   = DATA_WIDTH / 8
);
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i;
   logic [DATA_WIDTH-1:0]             wbm_dat_o;
   logic [NUM_MASTERS-1:0]            wbm_we_i;
   logic [NUM_MASTERS*SEL_WIDTH-1:0]  wbm_sel_i;
   logic [NUM_MASTERS-1:0]            wbm_stb_i;
   logic [NUM_MASTERS-1:0]            wbm_cyc_i;
   logic [NUM_MASTERS-1:0]            wbm_ack_o;
   logic [NUM_MASTERS-1:0]            wbm_err_o;
   logic [NUM_MASTERS-1:0]            wbm_rty_o;
   logic [ADDR_WIDTH-1:0]             wbs_adr_o;
   logic [DATA_WIDTH-1:0]             wbs_dat_o;
   logic [DATA_WIDTH-1:0]             wbs_dat_i;
   logic                              wbs_we_o;
   logic [SEL_WIDTH-1:0]              wbs_sel_o;
   logic                              wbs_stb_o;
   logic                              wbs_cyc_o;
   logic                              wbs_ack_i;
   logic                              wbs_err_i;
   logic                              wbs_rty_i;
   logic [NUM_MASTERS-1:0]            grant_o;

   modport slave (
      input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
      input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
      output grant_o
   );

   modport master (
      output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
      output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
      input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
      input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_stb_o, wbs_cyc_o,
      input  grant_o
   );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter granting a whole cyc tenure per master.
// Define WB_ARB_WATCHDOG_EN to add a stall watchdog that aborts the cycle with err.
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DATA_WIDTH     = 128,
   parameter int ADDR_WIDTH     = 32,
   parameter int SEL_WIDTH      = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic            clk,
   input logic            rst,
   wb_rr_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_MASTERS);

`ifdef WB_ARB_WATCHDOG_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
`endif

   state_t                 state_r, state_nxt_s;
   logic [NUM_MASTERS-1:0] grant_r, grant_nxt_s;
   logic [IDX_W-1:0]       last_r, last_nxt_s, owner_s, pick_s;
   logic                   busy_s, live_s, wd_hit_s, term_s;
   logic [ADDR_WIDTH-1:0]  adr_s;
   logic [DATA_WIDTH-1:0]  dat_s;
   logic [SEL_WIDTH-1:0]   sel_s;
   logic                   we_s, stb_s, cyc_s;

   assign busy_s = (state_r == BUSY);
   assign live_s = busy_s & ~wd_hit_s;
   assign term_s = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;

   // Encode the one-hot grant into the owner index
   always_comb begin
      owner_s = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         owner_s = grant_r[i] ? IDX_W'(i) : owner_s;
      end
   end

   // Rotating priority: first requester after the last owner, wrapping around
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      pick_s = last_r;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx    = IDX_W'((int'(last_r) + k) % NUM_MASTERS);
         pick_s = (!found && bus.wbm_cyc_i[idx]) ? idx : pick_s;
         found  = found | bus.wbm_cyc_i[idx];
      end
   end

`ifdef WB_ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wd_cnt_r;

   assign wd_hit_s = busy_s && (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES));

   // Count consecutive stalled strobe cycles; any termination or idle strobe clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_r <= '0;
      end else if (busy_s && !wd_hit_s && stb_s && !term_s) begin
         wd_cnt_r <= wd_cnt_r + CNT_W'(1);
      end else begin
         wd_cnt_r <= '0;
      end
   end
`else
   assign wd_hit_s = 1'b0;
`endif

   // AND-OR mux of the granted master onto the slave port
   always_comb begin
      adr_s = '0;
      dat_s = '0;
      sel_s = '0;
      we_s  = 1'b0;
      stb_s = 1'b0;
      cyc_s = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         adr_s = adr_s | ({ADDR_WIDTH{grant_r[i]}} & bus.wbm_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
         dat_s = dat_s | ({DATA_WIDTH{grant_r[i]}} & bus.wbm_dat_i[i*DATA_WIDTH +: DATA_WIDTH]);
         sel_s = sel_s | ({SEL_WIDTH{grant_r[i]}} & bus.wbm_sel_i[i*SEL_WIDTH +: SEL_WIDTH]);
         we_s  = we_s  | (grant_r[i] & bus.wbm_we_i[i]);
         stb_s = stb_s | (grant_r[i] & bus.wbm_stb_i[i]);
         cyc_s = cyc_s | (grant_r[i] & bus.wbm_cyc_i[i]);
      end
   end

   assign bus.wbs_adr_o = adr_s;
   assign bus.wbs_dat_o = dat_s;
   assign bus.wbs_sel_o = sel_s;
   assign bus.wbs_we_o  = live_s & we_s;
   assign bus.wbs_stb_o = live_s & stb_s;
   assign bus.wbs_cyc_o = live_s & cyc_s;
   assign bus.wbm_dat_o = bus.wbs_dat_i;
   assign bus.wbm_ack_o = grant_r & {NUM_MASTERS{live_s & bus.wbs_ack_i}};
   assign bus.wbm_rty_o = grant_r & {NUM_MASTERS{live_s & bus.wbs_rty_i}};
   assign bus.wbm_err_o = grant_r & {NUM_MASTERS{(live_s & bus.wbs_err_i) | wd_hit_s}};
   assign bus.grant_o   = grant_r;

   // Next-state logic: grant in IDLE, release when the owner drops cyc
   always_comb begin
      state_nxt_s = state_r;
      grant_nxt_s = grant_r;
      last_nxt_s  = last_r;
      case (state_r)
         IDLE: begin
            if (|bus.wbm_cyc_i) begin
               state_nxt_s = BUSY;
               grant_nxt_s = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_s;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (!bus.wbm_cyc_i[owner_s]) begin
               state_nxt_s = IDLE;
               grant_nxt_s = '0;
               last_nxt_s  = owner_s;
`ifdef WB_ARB_WATCHDOG_EN
            end else if (wd_hit_s) begin
               state_nxt_s = ABORT;
`endif
            end else begin
               state_nxt_s = BUSY;
            end
         end
`ifdef WB_ARB_WATCHDOG_EN
         ABORT: begin
            if (!bus.wbm_cyc_i[owner_s]) begin
               state_nxt_s = IDLE;
               grant_nxt_s = '0;
               last_nxt_s  = owner_s;
            end else begin
               state_nxt_s = ABORT;
            end
         end
`endif
         default: begin
            state_nxt_s = IDLE;
            grant_nxt_s = '0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         grant_r <= '0;
         last_r  <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         state_r <= state_nxt_s;
         grant_r <= grant_nxt_s;
         last_r  <= last_nxt_s;
      end
   end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: vector table, directed corner sequences
// and a randomized run against a tenure-level reference model.
module tb_wb_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 128;
   localparam int AW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic          m_cyc [N];
   logic          m_stb [N];
   logic          m_we  [N];
   logic [AW-1:0] m_adr [N];
   logic [DW-1:0] m_dat [N];
   logic [SW-1:0] m_sel [N];

   wb_rr_arbiter_if #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

   wb_rr_arbiter #(
      .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [N-1:0] cyc;
      logic         ack;
      logic [N-1:0] grant;
      logic         scyc;
      logic [N-1:0] mack;
   } vec_t;

   vec_t vecs [23];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL tb_timeout: simulation exceeded its time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.wbm_cyc_i[i]            = m_cyc[i];
         bus.wbm_stb_i[i]            = m_stb[i];
         bus.wbm_we_i[i]             = m_we[i];
         bus.wbm_adr_i[i*AW +: AW]   = m_adr[i];
         bus.wbm_dat_i[i*DW +: DW]   = m_dat[i];
         bus.wbm_sel_i[i*SW +: SW]   = m_sel[i];
      end
   endtask

   task automatic set_m(input int i, input logic c, input logic w, input logic [AW-1:0] a);
      m_cyc[i] = c;
      m_stb[i] = c;
      m_we[i]  = w;
      m_adr[i] = a;
      m_dat[i] = {4{a}};
      m_sel[i] = SW'(a);
      drive();
   endtask

   task automatic slv(input logic a, input logic e, input logic r);
      bus.wbs_ack_i = a;
      bus.wbs_err_i = e;
      bus.wbs_rty_i = r;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin
         m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
         m_adr[i] = '0;   m_dat[i] = '0;   m_sel[i] = '0;
      end
      drive();
      slv(1'b0, 1'b0, 1'b0);
      bus.wbs_dat_i = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_all();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Reference model state: tenure owner (-1 = none) and last owner
   int mdl_owner;
   int mdl_last;
   int stall;

   initial begin
      logic [N-1:0]  cycv;
      logic [DW-1:0] sdat;
      logic          ea, ee, er, exp_stb;
      int            o, r;

      checks = 0;
      errors = 0;
      rst    = 1'b0;
      clear_all();

      vecs[0]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[1]  = '{4'b1011, 1'b1, 4'b0001, 1'b1, 4'b0001};
      vecs[2]  = '{4'b1010, 1'b0, 4'b0001, 1'b0, 4'b0000};
      vecs[3]  = '{4'b1010, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[4]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 4'b0010};
      vecs[5]  = '{4'b1000, 1'b0, 4'b0010, 1'b0, 4'b0000};
      vecs[6]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[7]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000};
      vecs[8]  = '{4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0000};
      vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[10] = '{4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[11] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001};
      vecs[12] = '{4'b0010, 1'b0, 4'b0001, 1'b0, 4'b0000};
      vecs[13] = '{4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[14] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 4'b0010};
      vecs[15] = '{4'b0001, 1'b0, 4'b0010, 1'b0, 4'b0000};
      vecs[16] = '{4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[17] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001};
      vecs[18] = '{4'b0010, 1'b0, 4'b0001, 1'b0, 4'b0000};
      vecs[19] = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000};
      vecs[20] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010};
      vecs[21] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000};
      vecs[22] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_grant", bus.grant_o, '0);
      chk("rst_wbs_cyc", bus.wbs_cyc_o, '0);
      chk("rst_wbs_stb", bus.wbs_stb_o, '0);
      chk("rst_wbs_we", bus.wbs_we_o, '0);
      chk("rst_terms", {bus.wbm_ack_o, bus.wbm_err_o, bus.wbm_rty_o}, '0);

      // Vector table: simultaneous requests 0,1,3 then alternating fairness 0/1
      do_reset();
      for (int v = 0; v < 23; v++) begin
         for (int i = 0; i < N; i++) set_m(i, vecs[v].cyc[i], 1'b0, AW'(32'h100 * (i + 1)));
         slv(vecs[v].ack, 1'b0, 1'b0);
         #1;
         chk($sformatf("vec%0d_grant", v), bus.grant_o, vecs[v].grant);
         chk($sformatf("vec%0d_wbs_cyc", v), bus.wbs_cyc_o, vecs[v].scyc);
         chk($sformatf("vec%0d_wbs_stb", v), bus.wbs_stb_o, vecs[v].scyc);
         chk($sformatf("vec%0d_ack", v), bus.wbm_ack_o, vecs[v].mack);
         @(negedge clk);
      end

      // Single request: master 2 write to 0x1000, acked on the third busy cycle
      do_reset();
      set_m(2, 1'b1, 1'b1, 32'h0000_1000);
      #1;
      chk("single_idle_grant", bus.grant_o, 4'b0000);
      @(negedge clk);
      #1;
      chk("single_grant", bus.grant_o, 4'b0100);
      chk("single_adr", bus.wbs_adr_o, 32'h0000_1000);
      chk("single_we", bus.wbs_we_o, 1'b1);
      chk("single_dat", bus.wbs_dat_o, {4{32'h0000_1000}});
      chk("single_ack_c1", bus.wbm_ack_o, 4'b0000);
      @(negedge clk);
      #1;
      chk("single_ack_c2", bus.wbm_ack_o, 4'b0000);
      @(negedge clk);
      slv(1'b1, 1'b0, 1'b0);
      bus.wbs_dat_i = {4{32'hCAFE_F00D}};
      #1;
      chk("single_ack_c3", bus.wbm_ack_o, 4'b0100);
      chk("single_rdata", bus.wbm_dat_o, {4{32'hCAFE_F00D}});
      @(negedge clk);
      slv(1'b0, 1'b0, 1'b0);
      set_m(2, 1'b0, 1'b0, 32'h0);
      #1;
      chk("single_ack_c4", bus.wbm_ack_o, 4'b0000);

      // Multi-beat hold: master 1 holds 4 beats while master 0 waits
      @(negedge clk);
      set_m(1, 1'b1, 1'b0, 32'h0000_2000);
      @(negedge clk);
      set_m(0, 1'b1, 1'b0, 32'h0000_3000);
      for (int b = 0; b < 4; b++) begin
         slv(1'b1, 1'b0, 1'b0);
         #1;
         chk($sformatf("hold_grant_b%0d", b), bus.grant_o, 4'b0010);
         chk($sformatf("hold_ack_b%0d", b), bus.wbm_ack_o, 4'b0010);
         @(negedge clk);
      end
      slv(1'b0, 1'b0, 1'b0);
      set_m(1, 1'b0, 1'b0, 32'h0);
      #1;
      chk("hold_drop_cyc", bus.wbs_cyc_o, 1'b0);
      @(negedge clk);
      #1;
      chk("hold_dead_grant", bus.grant_o, 4'b0000);
      @(negedge clk);
      #1;
      chk("hold_next_grant", bus.grant_o, 4'b0001);
      chk("hold_next_adr", bus.wbs_adr_o, 32'h0000_3000);
      set_m(0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);

      // Stalled slave: watchdog abort, or indefinite hold without it
      do_reset();
      set_m(0, 1'b1, 1'b0, 32'h0000_4000);
      @(negedge clk);
`ifdef WB_ARB_WATCHDOG_EN
      for (int k = 1; k <= TO; k++) begin
         #1;
         chk($sformatf("wd_err_c%0d", k), bus.wbm_err_o, 4'b0000);
         chk($sformatf("wd_cyc_c%0d", k), bus.wbs_cyc_o, 1'b1);
         @(negedge clk);
      end
      #1;
      chk("wd_err_hit", bus.wbm_err_o, 4'b0001);
      chk("wd_cyc_hit", bus.wbs_cyc_o, 1'b0);
      @(negedge clk);
      slv(1'b1, 1'b0, 1'b0);
      #1;
      chk("wd_err_abort", bus.wbm_err_o, 4'b0000);
      chk("wd_cyc_abort", bus.wbs_cyc_o, 1'b0);
      chk("wd_ack_abort", bus.wbm_ack_o, 4'b0000);
      slv(1'b0, 1'b0, 1'b0);
      set_m(0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      #1;
      chk("wd_release", bus.grant_o, 4'b0000);
`else
      repeat (99) @(negedge clk);
      #1;
      chk("stall_cyc_c100", bus.wbs_cyc_o, 1'b1);
      chk("stall_grant_c100", bus.grant_o, 4'b0001);
      chk("stall_err_c100", bus.wbm_err_o, 4'b0000);
      set_m(0, 1'b0, 1'b0, 32'h0);
`endif
      @(negedge clk);

      // Asynchronous reset mid-tenure, then master 0 wins over 1 and 3
      set_m(2, 1'b1, 1'b1, 32'h0000_5000);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      slv(1'b1, 1'b0, 1'b0);
      #1;
      chk("arst_cyc", bus.wbs_cyc_o, 1'b0);
      chk("arst_grant", bus.grant_o, 4'b0000);
      chk("arst_ack", bus.wbm_ack_o, 4'b0000);
      clear_all();
      set_m(1, 1'b1, 1'b0, 32'h10);
      set_m(3, 1'b1, 1'b0, 32'h30);
      set_m(0, 1'b1, 1'b0, 32'h00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("arst_prio", bus.grant_o, 4'b0001);

      // Randomized traffic against the tenure-level model
      do_reset();
      mdl_owner = -1;
      mdl_last  = N - 1;
      stall     = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (m_cyc[i]) m_cyc[i] = ($urandom_range(0, 4) != 0);
            else          m_cyc[i] = ($urandom_range(0, 2) == 0);
            m_stb[i] = m_cyc[i] & $urandom_range(0, 1);
            m_we[i]  = 1'($urandom);
            m_adr[i] = $urandom;
            m_dat[i] = {$urandom, $urandom, $urandom, $urandom};
            m_sel[i] = SW'($urandom);
         end
         drive();
         o       = mdl_owner;
         exp_stb = (o >= 0) ? m_stb[o] : 1'b0;
         ea = 1'b0; ee = 1'b0; er = 1'b0;
         r  = $urandom_range(0, 9);
         if (exp_stb) begin
            if (stall >= 3 || r < 4) ea = 1'b1;
            else if (r == 4)         ee = 1'b1;
            else if (r == 5)         er = 1'b1;
         end else if (r < 3) begin
            ea = 1'b1;
         end
         slv(ea, ee, er);
         sdat = {$urandom, $urandom, $urandom, $urandom};
         bus.wbs_dat_i = sdat;
         #1;
         chk("rnd_grant", bus.grant_o, (o >= 0) ? (4'b0001 << o) : 4'b0000);
         chk("rnd_wbs_cyc", bus.wbs_cyc_o, (o >= 0) ? m_cyc[o] : 1'b0);
         chk("rnd_wbs_stb", bus.wbs_stb_o, exp_stb);
         chk("rnd_wbs_we", bus.wbs_we_o, (o >= 0) ? m_we[o] : 1'b0);
         if (o >= 0) begin
            chk("rnd_wbs_adr", bus.wbs_adr_o, m_adr[o]);
            chk("rnd_wbs_dat", bus.wbs_dat_o, m_dat[o]);
            chk("rnd_wbs_sel", bus.wbs_sel_o, m_sel[o]);
         end
         chk("rnd_ack", bus.wbm_ack_o, (o >= 0 && ea) ? (4'b0001 << o) : 4'b0000);
         chk("rnd_err", bus.wbm_err_o, (o >= 0 && ee) ? (4'b0001 << o) : 4'b0000);
         chk("rnd_rty", bus.wbm_rty_o, (o >= 0 && er) ? (4'b0001 << o) : 4'b0000);
         chk("rnd_rdata", bus.wbm_dat_o, sdat);
         @(posedge clk);
         stall = (exp_stb && !(ea || ee || er)) ? stall + 1 : 0;
         for (int i = 0; i < N; i++) cycv[i] = m_cyc[i];
         if (mdl_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
               if (mdl_owner < 0 && cycv[(mdl_last + k) % N]) mdl_owner = (mdl_last + k) % N;
            end
         end else if (!cycv[mdl_owner]) begin
            mdl_last  = mdl_owner;
            mdl_owner = -1;
         end
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
